// File: rtl/sr04_uart_pkg.sv
// Shared types and constants for the SR04 distance-to-ASCII frame transmitter.
// Frame layout depends on SR04_UNIT_SUFFIX_EN ("DDDcm\r\n" when defined, "DDD\r\n" otherwise).
package sr04_uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HUND = 2'd1,
    S_TENS = 2'd2,
    S_SEND = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_C  = 8'h63;
  localparam logic [7:0] ASCII_M  = 8'h6D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int FRAME_LEN_SUFFIX   = 7;
  localparam int FRAME_LEN_NOSUFFIX = 5;

`ifdef SR04_UNIT_SUFFIX_EN
  localparam int FRAME_LEN = FRAME_LEN_SUFFIX;
`else
  localparam int FRAME_LEN = FRAME_LEN_NOSUFFIX;
`endif

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return ASCII_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin2dec_sub_seq.sv
// Repeated-subtraction binary-to-decimal converter, one subtraction per cycle.
// The owner sequences it: i_start loads, i_hund_step / i_tens_step enable each phase.
module bin2dec_sub_seq #(
  parameter int DIST_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DIST_W-1:0] i_value,
  input  logic              i_hund_step,
  input  logic              i_tens_step,
  output logic              o_hund_done,
  output logic              o_ready,
  output logic [3:0]        o_hund,
  output logic [3:0]        o_tens,
  output logic [3:0]        o_ones
);

  logic [DIST_W-1:0] r_rem;
  logic [3:0]        r_hund;
  logic [3:0]        r_tens;
  logic              w_ge100;
  logic              w_ge10;

  assign w_ge100     = (r_rem >= DIST_W'(100));
  assign w_ge10      = (r_rem >= DIST_W'(10));
  assign o_hund_done = !w_ge100;
  assign o_ready     = !w_ge10;
  assign o_hund      = r_hund;
  assign o_tens      = r_tens;
  // Once the tens phase is exhausted the remainder is the ones digit and stays put.
  assign o_ones      = r_rem[3:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem  <= '0;
      r_hund <= '0;
      r_tens <= '0;
    end else if (i_start) begin
      r_rem  <= i_value;
      r_hund <= '0;
      r_tens <= '0;
    end else if (i_hund_step && w_ge100) begin
      r_rem  <= r_rem - DIST_W'(100);
      r_hund <= r_hund + 4'd1;
    end else if (i_tens_step && w_ge10) begin
      r_rem  <= r_rem - DIST_W'(10);
      r_tens <= r_tens + 4'd1;
    end
  end

endmodule

// File: rtl/sr04_dist_ascii_tx.sv
// Latches an SR04 distance on done, converts it to 3 decimal digits and pushes an ASCII frame
// into a UART TX FIFO. SR04_UNIT_SUFFIX_EN adds the "cm" suffix to the frame.
module sr04_dist_ascii_tx
  import sr04_uart_pkg::*;
#(
  parameter int DIST_W   = 9,
  parameter int MAX_DIST = 400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [DIST_W-1:0] distance,
  input  logic              tx_full,
  output logic              push,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              dropped,
  output state_t            dbg_state
);

  // FIFO handshake: a byte transfers on every cycle where push is high (push = SEND && !tx_full);
  // tx_data is stable until it transfers, so back-pressure never skips or repeats a byte.

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_byte_idx;
  logic [DIST_W-1:0] w_clamped;
  logic              w_start;
  logic              w_hund_done;
  logic              w_ready;
  logic [3:0]        w_hund;
  logic [3:0]        w_tens;
  logic [3:0]        w_ones;
  logic [7:0]        w_byte;

  assign w_clamped = (distance > DIST_W'(MAX_DIST)) ? DIST_W'(MAX_DIST) : distance;
  assign w_start   = (r_state == S_IDLE) && done;
  assign busy      = (r_state != S_IDLE);
  assign dropped   = done && busy;
  assign dbg_state = r_state;

  bin2dec_sub_seq #(.DIST_W(DIST_W)) u_bin2dec (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_start     (w_start),
    .i_value     (w_clamped),
    .i_hund_step (r_state == S_HUND),
    .i_tens_step (r_state == S_TENS),
    .o_hund_done (w_hund_done),
    .o_ready     (w_ready),
    .o_hund      (w_hund),
    .o_tens      (w_tens),
    .o_ones      (w_ones)
  );

  always_comb begin
    w_byte = 8'h00;
    case (r_byte_idx)
      3'd0: w_byte = digit_to_ascii(w_hund);
      3'd1: w_byte = digit_to_ascii(w_tens);
      3'd2: w_byte = digit_to_ascii(w_ones);
`ifdef SR04_UNIT_SUFFIX_EN
      3'd3: w_byte = ASCII_C;
      3'd4: w_byte = ASCII_M;
      3'd5: w_byte = ASCII_CR;
      3'd6: w_byte = ASCII_LF;
`else
      3'd3: w_byte = ASCII_CR;
      3'd4: w_byte = ASCII_LF;
`endif
      default: w_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    push    = 1'b0;
    tx_data = 8'h00;
    case (r_state)
      S_IDLE: if (done) w_next = S_HUND;
      S_HUND: if (w_hund_done) w_next = S_TENS;
      S_TENS: if (w_ready) w_next = S_SEND;
      S_SEND: begin
        tx_data = w_byte;
        push    = !tx_full;
        if (push && (r_byte_idx == LAST_IDX)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_byte_idx <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_TENS && w_ready) r_byte_idx <= '0;
      else if (push) r_byte_idx <= r_byte_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_sr04_dist_ascii_tx.sv
// Randomized bench for sr04_dist_ascii_tx: frames are predicted from decimal arithmetic on the
// clamped distance and compared byte-by-byte with what the DUT pushes.
module tb_sr04_dist_ascii_tx;
  import sr04_uart_pkg::*;

`ifdef SR04_UNIT_SUFFIX_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 5;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       done;
  logic [8:0] distance;
  logic       tx_full;
  logic       push;
  logic [7:0] tx_data;
  logic       busy;
  logic       dropped;
  state_t     dbg_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  sr04_dist_ascii_tx dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .distance  (distance),
    .tx_full   (tx_full),
    .push      (push),
    .tx_data   (tx_data),
    .busy      (busy),
    .dropped   (dropped),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: decimal digits of min(d,400) followed by the frame suffix
  function automatic void build_exp(input int d);
    int v;
    v = (d > 400) ? 400 : d;
    exp_q.delete();
    exp_q.push_back(8'(48 + v / 100));
    exp_q.push_back(8'(48 + (v / 10) % 10));
    exp_q.push_back(8'(48 + v % 10));
`ifdef SR04_UNIT_SUFFIX_EN
    exp_q.push_back(8'h63);
    exp_q.push_back(8'h6D);
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // drivers: inputs change 1 time unit after posedge, outputs sampled at negedge
  task automatic step(input logic f, input logic d);
    @(posedge clk);
    #1;
    tx_full = f;
    done    = d;
    @(negedge clk);
  endtask

  task automatic start_frame(input int d);
    @(posedge clk);
    #1;
    distance = 9'(d);
    done     = 1'b1;
    tx_full  = 1'b0;
    @(negedge clk);
  endtask

  task automatic collect(input int full_pct, input int budget,
                         output int first_k, output int last_k, output bit ok);
    logic f;
    got_q.delete();
    first_k = -1;
    last_k  = -1;
    ok      = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      f = (full_pct > 0) && ($urandom_range(99) < full_pct);
      step(f, 1'b0);
      if (push) begin
        got_q.push_back(tx_data);
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      if (!busy && got_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    tx_full = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; done = 1'b0; distance = '0; tx_full = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (push !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || dropped !== 1'b0 ||
        dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL reset_outputs push=%b data=%h busy=%b dropped=%b state=%0d expected 0 00 0 0 0",
               push, tx_data, busy, dropped, dbg_state);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frames();
    int dl[12] = '{123, 7, 0, 399, 400, 401, 450, 511, 100, 99, 10, 9};
    int fk, lk;
    bit ok;
    for (int i = 0; i < 12; i++) begin
      build_exp(dl[i]);
      start_frame(dl[i]);
      total++;
      if (dropped !== 1'b0) begin
        bad++; $display("FAIL idle_done_dropped d=%0d dropped=%b expected 0", dl[i], dropped);
      end
      collect(0, 100, fk, lk, ok);
      total++;
      if (!ok || got_q.size() != exp_q.size()) begin
        bad++; $display("FAIL frame_len d=%0d got=%0d expected=%0d done_ok=%0d", dl[i], got_q.size(), exp_q.size(), ok);
      end else begin
        foreach (got_q[j]) begin
          total++;
          if (got_q[j] !== exp_q[j]) begin
            bad++; $display("FAIL frame_byte d=%0d idx=%0d got=%h expected=%h", dl[i], j, got_q[j], exp_q[j]);
          end
        end
      end
      total++;
      if (fk < 1 || fk > 16 || (lk - fk) != FLEN - 1) begin
        bad++; $display("FAIL latency_burst d=%0d first=%0d span=%0d expected first<=16 span=%0d", dl[i], fk, lk - fk, FLEN - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int stall_cnt = 0;
    bit fin = 1'b0;
    logic f;
    build_exp(256);
    start_frame(256);
    got_q.delete();
    for (int k = 0; k < 100 && !fin; k++) begin
      f = (got_q.size() == 2) && (stall_cnt < 5);
      step(f, 1'b0);
      if (f) begin
        stall_cnt++;
        total++;
        if (push !== 1'b0 || tx_data !== 8'h36) begin
          bad++; $display("FAIL stall_hold cyc=%0d push=%b data=%h expected 0 36", stall_cnt, push, tx_data);
        end
      end
      if (push) got_q.push_back(tx_data);
      if (!busy && got_q.size() > 0) fin = 1'b1;
    end
    tx_full = 1'b0;
    total++;
    if (got_q != exp_q || stall_cnt != 5) begin
      bad++; $display("FAIL stall_frame got_len=%0d expected_len=%0d stalls=%0d expected 5", got_q.size(), exp_q.size(), stall_cnt);
    end
  endtask

  task automatic test_drop_during_send();
    bit sent = 1'b0;
    bit chk_next = 1'b0;
    bit fin = 1'b0;
    logic d_now;
    int extra = 0;
    build_exp(99);
    start_frame(99);
    got_q.delete();
    for (int k = 0; k < 100 && !fin; k++) begin
      d_now = (got_q.size() == 2) && !sent;
      step(1'b0, d_now);
      if (chk_next) begin
        chk_next = 1'b0;
        total++;
        if (dropped !== 1'b0) begin
          bad++; $display("FAIL drop_width dropped=%b expected 0", dropped);
        end
      end
      if (d_now) begin
        sent = 1'b1; chk_next = 1'b1;
        total++;
        if (dropped !== 1'b1) begin
          bad++; $display("FAIL drop_pulse dropped=%b expected 1", dropped);
        end
      end
      if (push) got_q.push_back(tx_data);
      if (!busy && got_q.size() > 0) fin = 1'b1;
    end
    total++;
    if (got_q != exp_q) begin
      bad++; $display("FAIL drop_frame got_len=%0d expected_len=%0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b0);
      if (push || busy) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL drop_second_frame active_cycles=%0d expected 0", extra);
    end
  endtask

  task automatic test_done_on_last();
    int d;
    bit sent = 1'b0;
    bit fin = 1'b0;
    logic d_now;
    int extra = 0;
    d = $urandom_range(511);
    build_exp(d);
    start_frame(d);
    got_q.delete();
    for (int k = 0; k < 100 && !fin; k++) begin
      d_now = (got_q.size() == FLEN - 1) && !sent;
      step(1'b0, d_now);
      if (d_now) begin
        sent = 1'b1;
        total++;
        if (push !== 1'b1 || dropped !== 1'b1) begin
          bad++; $display("FAIL last_push_done push=%b dropped=%b expected 1 1", push, dropped);
        end
      end
      if (push) got_q.push_back(tx_data);
      if (!busy && got_q.size() > 0) fin = 1'b1;
    end
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b0);
      if (push || busy) extra++;
    end
    total++;
    if (got_q != exp_q || extra != 0) begin
      bad++; $display("FAIL last_push_frame d=%0d got_len=%0d expected_len=%0d extra=%0d", d, got_q.size(), exp_q.size(), extra);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fk, lk, extra = 0;
    bit ok;
    start_frame(321);
    got_q.delete();
    for (int k = 0; k < 100 && got_q.size() < 3; k++) begin
      step(1'b0, 1'b0);
      if (push) got_q.push_back(tx_data);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total++;
    if (push !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || got_q.size() != 3) begin
      bad++; $display("FAIL reset_mid push=%b busy=%b data=%h seen=%0d expected 0 0 00 3", push, busy, tx_data, got_q.size());
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0);
      if (push || busy) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL reset_partial_resumed active_cycles=%0d expected 0", extra);
    end
    build_exp(42);
    start_frame(42);
    collect(0, 100, fk, lk, ok);
    total++;
    if (!ok || got_q != exp_q) begin
      bad++; $display("FAIL after_reset_frame got_len=%0d expected_len=%0d done_ok=%0d", got_q.size(), exp_q.size(), ok);
    end
  endtask

  task automatic test_random_backpressure();
    int d, fk, lk;
    bit ok;
    for (int n = 0; n < 20; n++) begin
      d = $urandom_range(511);
      build_exp(d);
      start_frame(d);
      collect(40, 400, fk, lk, ok);
      total++;
      if (!ok || got_q != exp_q) begin
        bad++;
        $display("FAIL random_frame d=%0d got_len=%0d expected_len=%0d first_got=%h first_expected=%h",
                 d, got_q.size(), exp_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00, exp_q[0]);
      end
      repeat ($urandom_range(3)) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_backpressure();
    test_drop_during_send();
    test_done_on_last();
    test_reset_mid_frame();
    test_random_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
